bitserial_mac_ctrl: RTL and testbench
=====================================

Name: bitserial_mac_ctrl

Overview:
Runtime-precision, bit-serial MAC sequencer for the QR charge-domain array. It accepts one vector of two's-complement activations and issues it to the array one bit-plane per cycle, MSB first. It then accumulates the signed ADC results with a shift-add into a per-column accumulator. Results are presented on a valid/ready output with full backpressure. It replaces the fixed-precision, no-backpressure sequencer and sits between the activation buffer and qr_acc_wrapper.

Parameters:
maxInputBits, 8, maximum activation precision (two's complement); sets the PISO depth.
inputElements, 128, array rows / activation lanes.
outputElements, 32, array columns / result lanes.
adcBits, 4, signed ADC output width per column.
adcLatency, 1, cycles from mac_en_o/data driven to matching adc_i sample; must be at least 1.
outBits, 8, result width per column on mac_data_o.
accBits (localparam), adcBits + maxInputBits, internal accumulator width.

Ports:
clk  in  1  clock
nrst  in  1  reset, synchronous, active-low
cfg_n_bits_i  in  $clog2(maxInputBits+1)  activation precision; sampled at input handshake
in_data_i  in  inputElements*maxInputBits  activations, LSB-aligned, sign in bit n-1
in_valid_i  in  1  input valid
in_ready_o  out  1  input ready
mac_en_o  out  1  array evaluate strobe
data_p_o  out  inputElements  positive bit-plane drive
data_n_o  out  inputElements  negative bit-plane drive
adc_i  in  outputElements*adcBits  signed per-column ADC codes
out_data_o  out  outputElements*outBits  signed results
out_valid_o  out  1  result valid
out_ready_i  in  1  result ready
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset (sync, nrst=0): state IDLE; accumulators, PISO, counters and ADC pipe cleared. Reset outputs: in_ready_o=1, out_valid_o=0, mac_en_o=0, data_p_o=0, data_n_o=0, out_data_o=0, busy_o=0. Reset mid-operation abandons the job; no partial result is emitted.
- States:
  - IDLE: in_ready_o=1. On in_valid_i&&in_ready_o: latch data, latch n=clamp(cfg_n_bits_i), cnt=n-1, go to ISSUE. Clamp: values below 2 become 2; values above maxInputBits become maxInputBits.
  - ISSUE: n cycles. mac_en_o=1. Bit index cnt drives the lanes, MSB first.
    - cnt==n-1 (sign bit): data_n_o=bit, data_p_o=0.
    - Otherwise: data_p_o=bit, data_n_o=0.
    - cnt decrements each cycle; after cnt==0, go to WAIT.
  - WAIT: adcLatency cycles with mac_en_o=0 and data_p_o=data_n_o=0, until the last ADC sample is accumulated; then go to HOLD.
  - HOLD: out_valid_o=1 and out_data_o stable. On out_ready_i, go to IDLE. in_ready_o=0 in every state except IDLE.
- ADC alignment: a valid/first flag travels through an adcLatency-deep shift register alongside mac_en_o.
  - Flagged sample, first plane: acc = sext(adc).
  - Flagged sample, later planes: acc = (acc <<< 1) + sext(adc).
  - All arithmetic is signed at accBits width; no overflow is possible at this width.
- Output narrowing: out_data_o = low outBits of acc; see the Optional Feature.
- Latency: handshake at cycle T gives first mac_en_o at T+1, last at T+n, last accumulate at T+n+adcLatency, out_valid_o at T+n+adcLatency+1. Example: n=4, adcLatency=1 gives T+6.
- Throughput: one job per n+adcLatency+2 cycles when out_ready_i is held high.
- The next job is accepted only in IDLE. in_valid_i during any other state is ignored and not consumed.
- cfg_n_bits_i changes outside the handshake cycle have no effect on an in-flight job.

Optional Feature:
BITSERIAL_MAC_SAT_EN:
- Defined: out_data_o saturates acc to the signed outBits range [-2^(outBits-1), 2^(outBits-1)-1].
- Undefined: out_data_o is the truncated low outBits bits (wrap).
- Handshake timing is identical in both cases.

Decomposition:
- qracc_pkg gains:
  - bsmac_state_e enum: IDLE, ISSUE, WAIT, HOLD.
  - Constant BSMAC_MIN_BITS=2.
  - A sign-extend/saturate function, so other consumers can reuse it.
- One sub-module: bsmac_piso. It holds the latched activation vector and produces data_p/data_n for a given bit index and sign flag. The FSM and accumulators stay in the top module.

Test Plan:
- Setup for all scenarios: inputElements=4, outputElements=2, behavioural array adc = sum(w*(p-n)) with w=+1, adcLatency=1.
- n=4, inputs {3,-2,5,-8} -> out_data_o={-2,-2}; out_valid_o first high exactly 6 cycles after the handshake.
- n=2, inputs {1,-2,1,-1} -> {-1,-1}. cfg_n_bits_i=0 -> treated as n=2 with identical result. cfg_n_bits_i=15 -> treated as n=maxInputBits.
- Backpressure: hold out_ready_i=0 for 10 cycles -> out_valid_o stays 1, out_data_o stable, in_ready_o=0, and a pending in_valid_i is not consumed. Release -> IDLE next cycle, and the pending input is accepted.
- Saturation, outBits=4, n=4, inputs {7,7,6,0} (acc=20):
  - With BITSERIAL_MAC_SAT_EN -> 7.
  - Without -> 4.
  - Inputs {-8,-8,-8,0} -> -8 in both builds.
- Reset: assert nrst=0 for one cycle during ISSUE (cnt=1) -> next cycle IDLE, in_ready_o=1, mac_en_o=0, no out_valid_o pulse. A subsequent job returns the correct result.
- Back-to-back jobs with out_ready_i=1 -> one result per n+3 cycles. Results are in order, and the second result shows no residue from the first job's accumulator.

Source files
------------

// File: rtl/qracc_pkg.sv
// ---------------------------------------------------------------------------
// qracc_pkg
// Shared types and helpers for the QR charge-domain accelerator slice.
//   bsmac_state_e  : sequencer states of bitserial_mac_ctrl
//   BSMAC_MIN_BITS : smallest activation precision the sequencer will run
//   bsmac_sext     : sign-extend the low `bits` bits of a value to 64 bits
//   bsmac_sat      : clamp a signed value into the signed `bits`-bit range
// ---------------------------------------------------------------------------
package qracc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } bsmac_state_e;

  // Precision 1 would leave only a sign plane, so the floor is 2.
  localparam int BSMAC_MIN_BITS = 2;

  // Valid for 1 <= bits <= 64.
  function automatic logic signed [63:0] bsmac_sext(input logic [63:0] v,
                                                    input int          bits);
    logic signed [63:0] t;
    t = $signed(v << (64 - bits));
    return t >>> (64 - bits);
  endfunction

  // Valid for 1 <= bits <= 63.
  function automatic logic signed [63:0] bsmac_sat(input logic signed [63:0] v,
                                                   input int                 bits);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (bits - 1));
    if (v > hi) begin
      return hi;
    end
    if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/bsmac_piso.sv
// ---------------------------------------------------------------------------
// bsmac_piso
// Holds one activation vector and presents a single bit-plane of it on the
// differential array drive. The sign plane goes out on data_n (negative
// weight), all other planes on data_p.
//   clk, nrst   : clock, synchronous active-low reset
//   load_i      : capture data_i (one vector, lanes of maxInputBits bits)
//   en_i        : drive the selected plane; both drives are 0 when low
//   sign_i      : selected plane is the sign plane
//   bit_idx_i   : plane index within each lane
//   data_p_o    : positive plane drive, one bit per lane
//   data_n_o    : negative plane drive, one bit per lane
// ---------------------------------------------------------------------------
module bsmac_piso #(
  parameter int maxInputBits  = 8,
  parameter int inputElements = 128,
  localparam int CW = (maxInputBits > 1) ? $clog2(maxInputBits) : 1
) (
  input  logic                                  clk,
  input  logic                                  nrst,
  input  logic                                  load_i,
  input  logic [inputElements*maxInputBits-1:0] data_i,
  input  logic                                  en_i,
  input  logic                                  sign_i,
  input  logic [CW-1:0]                         bit_idx_i,
  output logic [inputElements-1:0]              data_p_o,
  output logic [inputElements-1:0]              data_n_o
);

  logic [inputElements*maxInputBits-1:0] data_q;
  logic [inputElements*maxInputBits-1:0] data_d;

  always_comb begin
    data_d = load_i ? data_i : data_q;
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  always_comb begin
    logic [maxInputBits-1:0] lane;
    logic                    plane_bit;
    data_p_o = '0;
    data_n_o = '0;
    for (int i = 0; i < inputElements; i++) begin
      lane      = data_q[i*maxInputBits +: maxInputBits];
      plane_bit = lane[bit_idx_i] & en_i;
      data_p_o[i] = plane_bit & ~sign_i;
      data_n_o[i] = plane_bit &  sign_i;
    end
  end

endmodule

// File: rtl/bitserial_mac_ctrl.sv
// ---------------------------------------------------------------------------
// bitserial_mac_ctrl
// Runtime-precision bit-serial MAC sequencer. Takes one vector of two's-
// complement activations, issues it MSB-first one bit-plane per cycle to the
// charge-domain array, shift-adds the signed per-column ADC codes, and holds
// the result on a valid/ready output until it is taken.
//
// Build option: define BITSERIAL_MAC_SAT_EN to saturate results to the signed
// outBits range; otherwise results are the wrapped low outBits bits.
//
// Ports
//   clk, nrst     : clock, synchronous active-low reset
//   cfg_n_bits_i  : activation precision, sampled at the input handshake
//   in_data_i     : activations, LSB-aligned per lane, sign in bit n-1
//   in_valid_i    : input valid
//   in_ready_o    : input ready (IDLE only)
//   mac_en_o      : array evaluate strobe
//   data_p_o      : positive bit-plane drive
//   data_n_o      : negative bit-plane drive (sign plane)
//   adc_i         : signed per-column ADC codes, adcLatency after mac_en_o
//   out_data_o    : signed per-column results
//   out_valid_o   : result valid (HOLD)
//   out_ready_i   : result ready
//   busy_o        : any state other than IDLE
// ---------------------------------------------------------------------------
module bitserial_mac_ctrl
  import qracc_pkg::*;
#(
  parameter int maxInputBits   = 8,
  parameter int inputElements  = 128,
  parameter int outputElements = 32,
  parameter int adcBits        = 4,
  parameter int adcLatency     = 1,
  parameter int outBits        = 8
) (
  input  logic                                  clk,
  input  logic                                  nrst,
  input  logic [$clog2(maxInputBits+1)-1:0]     cfg_n_bits_i,
  input  logic [inputElements*maxInputBits-1:0] in_data_i,
  input  logic                                  in_valid_i,
  output logic                                  in_ready_o,
  output logic                                  mac_en_o,
  output logic [inputElements-1:0]              data_p_o,
  output logic [inputElements-1:0]              data_n_o,
  input  logic [outputElements*adcBits-1:0]     adc_i,
  output logic [outputElements*outBits-1:0]     out_data_o,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic                                  busy_o
);

  localparam int accBits = adcBits + maxInputBits;
  localparam int NBW     = $clog2(maxInputBits + 1);
  localparam int CW      = (maxInputBits > 1) ? $clog2(maxInputBits) : 1;
  localparam int WW      = $clog2(adcLatency + 1);

  bsmac_state_e state_q, state_d;

  logic [NBW-1:0]        n_q, n_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WW-1:0]         wait_cnt_q, wait_cnt_d;
  logic [adcLatency-1:0] pipe_vld_q, pipe_vld_d;
  logic [adcLatency-1:0] pipe_first_q, pipe_first_d;

  logic signed [accBits-1:0] acc_q [outputElements];
  logic signed [accBits-1:0] acc_d [outputElements];

  logic           accept;
  logic           issue_sign;
  logic [NBW-1:0] n_clamped;

  assign accept = in_valid_i && in_ready_o;

  always_comb begin
    if (cfg_n_bits_i < NBW'(BSMAC_MIN_BITS)) begin
      n_clamped = NBW'(BSMAC_MIN_BITS);
    end else if (cfg_n_bits_i > NBW'(maxInputBits)) begin
      n_clamped = NBW'(maxInputBits);
    end else begin
      n_clamped = cfg_n_bits_i;
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)                               state_d = ISSUE;
      ISSUE:   if (cnt_q == '0)                          state_d = WAIT;
      WAIT:    if (wait_cnt_q == WW'(adcLatency - 1))    state_d = HOLD;
      HOLD:    if (out_ready_i)                          state_d = IDLE;
      default:                                           state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // NOTE: every signal written here gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    in_ready_o  = 1'b0;
    mac_en_o    = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b0;
      end
      ISSUE:   mac_en_o    = 1'b1;
      HOLD:    out_valid_o = 1'b1;
      default: ;
    endcase
  end

  // The first plane issued is the sign plane (index n-1).
  assign issue_sign = mac_en_o && (NBW'(cnt_q) == n_q - NBW'(1));

  // ---------------- counters and ADC alignment pipe ----------------
  always_comb begin
    n_d        = n_q;
    cnt_d      = cnt_q;
    wait_cnt_d = wait_cnt_q;
    if (accept) begin
      n_d   = n_clamped;
      cnt_d = CW'(n_clamped - NBW'(1));
    end else if (state_q == ISSUE && cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
    if (state_q == WAIT) begin
      wait_cnt_d = wait_cnt_q + WW'(1);
    end else begin
      wait_cnt_d = '0;
    end
    // The flags ride alongside each issued plane so the matching ADC sample
    // is recognised exactly adcLatency cycles later.
    pipe_vld_d   = (pipe_vld_q   << 1) | adcLatency'(mac_en_o);
    pipe_first_d = (pipe_first_q << 1) | adcLatency'(issue_sign);
  end

  // ---------------- shift-add accumulators ----------------
  always_comb begin
    logic signed [accBits-1:0] adc_sext;
    for (int c = 0; c < outputElements; c++) begin
      acc_d[c] = acc_q[c];
      adc_sext = accBits'(bsmac_sext(64'(adc_i[c*adcBits +: adcBits]), adcBits));
      if (pipe_vld_q[adcLatency-1]) begin
        if (pipe_first_q[adcLatency-1]) begin
          acc_d[c] = adc_sext;
        end else begin
          acc_d[c] = (acc_q[c] <<< 1) + adc_sext;
        end
      end
    end
  end

  // NOTE: the accumulator array is reset explicitly because out_data_o is
  // driven straight from it and must read zero out of reset; an unreset
  // array would leave the output undefined until the first job.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      n_q          <= NBW'(BSMAC_MIN_BITS);
      cnt_q        <= '0;
      wait_cnt_q   <= '0;
      pipe_vld_q   <= '0;
      pipe_first_q <= '0;
      for (int c = 0; c < outputElements; c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      n_q          <= n_d;
      cnt_q        <= cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_first_q <= pipe_first_d;
      for (int c = 0; c < outputElements; c++) begin
        acc_q[c] <= acc_d[c];
      end
    end
  end

  // ---------------- output narrowing ----------------
  always_comb begin
    out_data_o = '0;
    for (int c = 0; c < outputElements; c++) begin
`ifdef BITSERIAL_MAC_SAT_EN
      out_data_o[c*outBits +: outBits] = outBits'(bsmac_sat(64'(acc_q[c]), outBits));
`else
      out_data_o[c*outBits +: outBits] = outBits'(acc_q[c]);
`endif
    end
  end

  // ---------------- bit-plane source ----------------
  bsmac_piso #(
    .maxInputBits  (maxInputBits),
    .inputElements (inputElements)
  ) u_piso (
    .clk       (clk),
    .nrst      (nrst),
    .load_i    (accept),
    .data_i    (in_data_i),
    .en_i      (mac_en_o),
    .sign_i    (issue_sign),
    .bit_idx_i (cnt_q),
    .data_p_o  (data_p_o),
    .data_n_o  (data_n_o)
  );

endmodule

// File: tb/tb_bitserial_mac_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bitserial_mac_ctrl
// Self-checking bench for bitserial_mac_ctrl with 4 lanes, 2 columns,
// adcLatency 1 and 4-bit results. A behavioural array turns the plane drives
// into ADC codes one cycle later; expected results are the weighted sum of
// the n-bit two's-complement activations, narrowed to 4 bits.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bitserial_mac_ctrl;

  localparam int MB  = 8;
  localparam int IE  = 4;
  localparam int OE  = 2;
  localparam int AB  = 4;
  localparam int AL  = 1;
  localparam int OB  = 4;
  localparam int NBW = $clog2(MB + 1);

`ifdef BITSERIAL_MAC_SAT_EN
  localparam int SAT_EXP = 7;
`else
  localparam int SAT_EXP = 4;
`endif

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic [NBW-1:0]   cfg_n_bits_i = '0;
  logic [IE*MB-1:0] in_data_i = '0;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic             mac_en_o;
  logic [IE-1:0]    data_p_o;
  logic [IE-1:0]    data_n_o;
  logic [OE*AB-1:0] adc_i = '0;
  logic [OE*OB-1:0] out_data_o;
  logic             out_valid_o;
  logic             out_ready_i = 1'b1;
  logic             busy_o;

  bitserial_mac_ctrl #(
    .maxInputBits   (MB),
    .inputElements  (IE),
    .outputElements (OE),
    .adcBits        (AB),
    .adcLatency     (AL),
    .outBits        (OB)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .cfg_n_bits_i (cfg_n_bits_i),
    .in_data_i    (in_data_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .mac_en_o     (mac_en_o),
    .data_p_o     (data_p_o),
    .data_n_o     (data_n_o),
    .adc_i        (adc_i),
    .out_data_o   (out_data_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural array (latency 1) ----------------
  int w_col [OE];
  logic [OE*AB-1:0] adc_nxt = '0;

  always @(negedge clk) begin
    for (int c = 0; c < OE; c++) begin
      int s;
      s = 0;
      for (int i = 0; i < IE; i++) begin
        s += w_col[c] * (int'(data_p_o[i]) - int'(data_n_o[i]));
      end
      adc_nxt[c*AB +: AB] = AB'(s);
    end
  end

  always @(posedge clk) begin
    #1;
    adc_i = adc_nxt;
  end

  // ---------------- reference model ----------------
  function automatic int eff_n(input int cfg);
    int n;
    n = cfg;
    if (n < 2) n = 2;
    if (n > MB) n = MB;
    return n;
  endfunction

  function automatic int narrow(input int v);
    int m, h, r;
    m = 1 << OB;
    h = 1 << (OB - 1);
`ifdef BITSERIAL_MAC_SAT_EN
    r = (v > h - 1) ? h - 1 : ((v < -h) ? -h : v);
`else
    r = ((v % m) + m) % m;
    if (r >= h) r -= m;
`endif
    return r;
  endfunction

  function automatic int model(input int cfg, input logic [IE*MB-1:0] d, input int col);
    int n, sum, v;
    n   = eff_n(cfg);
    sum = 0;
    for (int i = 0; i < IE; i++) begin
      v = int'(d[i*MB +: MB]) & ((1 << n) - 1);
      if (v >= (1 << (n - 1))) v -= (1 << n);
      sum += w_col[col] * v;
    end
    return narrow(sum);
  endfunction

  function automatic logic [IE*MB-1:0] pack4(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  // ---------------- result monitor ----------------
  typedef struct {
    int d0;
    int d1;
    int cyc;
  } res_t;

  res_t got_q[$];

  always @(negedge clk) begin
    if (nrst && out_valid_o && out_ready_i) begin
      res_t r;
      r.d0  = int'($signed(out_data_o[OB-1:0]));
      r.d1  = int'($signed(out_data_o[2*OB-1:OB]));
      r.cyc = cyc;
      got_q.push_back(r);
    end
  end

  function automatic res_t pop_res();
    res_t r;
    r.d0  = -999;
    r.d1  = -999;
    r.cyc = 0;
    if (got_q.size() > 0) r = got_q.pop_front();
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // Presents one job and returns once the handshake edge has passed; hs is
  // the cycle number seen during the first cycle after the handshake.
  task automatic send(input logic [NBW-1:0] nb, input logic [IE*MB-1:0] d, output int hs);
    bit ok;
    ok           = 1'b0;
    cfg_n_bits_i = nb;
    in_data_i    = d;
    in_valid_i   = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_ready_o) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid_i   = 1'b0;
    hs           = cyc;
    // An in-flight job must ignore later precision changes.
    cfg_n_bits_i = NBW'($urandom);
    in_data_i    = {$urandom};
    check("input_accepted", int'(ok), 1);
  endtask

  task automatic wait_results(input int cnt);
    int k;
    k = 0;
    while (got_q.size() < cnt && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("result_arrived", int'(got_q.size() >= cnt), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input string nm, input logic [NBW-1:0] nb, input logic [IE*MB-1:0] d,
                         input int e0, input int e1, input int elat);
    int   hs;
    res_t r;
    send(nb, d, hs);
    wait_results(1);
    r = pop_res();
    check({nm, "_col0"}, r.d0, e0);
    check({nm, "_col1"}, r.d1, e1);
    check({nm, "_latency"}, r.cyc - hs + 1, elat);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string          name;
    logic [NBW-1:0] nb;
    logic [IE*MB-1:0] data;
    int             e0;
    int             e1;
    int             lat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   hs_a, hs_b, k, vcnt;
    res_t ra, rb;

    w_col[0] = 1;
    w_col[1] = 1;

    vecs[0] = '{"n4_basic",  NBW'(4),  pack4(3, -2, 5, -8),       -2, -2, 6};
    vecs[1] = '{"n2_basic",  NBW'(2),  pack4(1, -2, 1, -1),       -1, -1, 4};
    vecs[2] = '{"n0_clamp",  NBW'(0),  pack4(1, -2, 1, -1),       -1, -1, 4};
    vecs[3] = '{"n15_clamp", NBW'(15), pack4(100, -100, 60, -57),  3,  3, 10};
    vecs[4] = '{"n1_clamp",  NBW'(1),  pack4(1, 1, 1, 1),          4,  4, 4};
    vecs[5] = '{"sat_pos",   NBW'(4),  pack4(7, 7, 6, 0),    SAT_EXP, SAT_EXP, 6};
    vecs[6] = '{"sat_neg",   NBW'(4),  pack4(-8, -8, -8, 0),      -8, -8, 6};
    vecs[7] = '{"n3_basic",  NBW'(3),  pack4(3, 3, -4, -4),       -2, -2, 5};

    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  int'(in_ready_o),  1);
    check("rst_out_valid", int'(out_valid_o), 0);
    check("rst_mac_en",    int'(mac_en_o),    0);
    check("rst_data_p",    int'(data_p_o),    0);
    check("rst_data_n",    int'(data_n_o),    0);
    check("rst_out_data",  int'(out_data_o),  0);
    check("rst_busy",      int'(busy_o),      0);
    @(posedge clk);
    #1;
    nrst = 1'b1;

    // ---- table-driven jobs ----
    for (int i = 0; i < 8; i++) begin
      run_job(vecs[i].name, vecs[i].nb, vecs[i].data, vecs[i].e0, vecs[i].e1, vecs[i].lat);
    end

    // ---- backpressure: result held, pending input not consumed ----
    out_ready_i = 1'b0;
    send(NBW'(4), pack4(3, -2, 5, -8), hs_a);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid_o && k < 50);
    check("bp_valid_seen", int'(out_valid_o), 1);
    check("bp_latency", cyc - hs_a + 1, 6);
    @(posedge clk);
    #1;
    cfg_n_bits_i = NBW'(2);
    in_data_i    = pack4(1, -2, 1, -1);
    in_valid_i   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_valid", int'(out_valid_o), 1);
      check("bp_hold_data",  int'(out_data_o), 'hEE);
      check("bp_hold_ready", int'(in_ready_o), 0);
      @(posedge clk);
      #1;
    end
    check("bp_no_early_result", got_q.size(), 0);
    out_ready_i = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_release_ready", int'(in_ready_o), 1);
    check("bp_release_busy",  int'(busy_o), 0);
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    hs_b       = cyc;
    wait_results(2);
    ra = pop_res();
    rb = pop_res();
    check("bp_held_col0",    ra.d0, -2);
    check("bp_held_col1",    ra.d1, -2);
    check("bp_pending_col0", rb.d0, -1);
    check("bp_pending_col1", rb.d1, -1);
    check("bp_pending_lat",  rb.cyc - hs_b + 1, 4);

    // ---- back-to-back jobs, no residue ----
    send(NBW'(4), pack4(7, 7, 6, 0), hs_a);
    send(NBW'(4), pack4(1, 0, 0, 0), hs_b);
    wait_results(2);
    ra = pop_res();
    rb = pop_res();
    check("b2b_first",     ra.d0, SAT_EXP);
    check("b2b_second",    rb.d0, 1);
    check("b2b_second_c1", rb.d1, 1);
    check("b2b_accept_gap", hs_b - hs_a, 7);
    check("b2b_result_gap", rb.cyc - ra.cyc, 7);

    // ---- reset in the middle of ISSUE (cnt=1) ----
    send(NBW'(4), pack4(3, -2, 5, -8), hs_a);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    nrst = 1'b0;
    @(negedge clk);
    check("midrst_in_issue", int'(mac_en_o), 1);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", int'(in_ready_o), 1);
    check("midrst_mac_en",   int'(mac_en_o), 0);
    check("midrst_busy",     int'(busy_o), 0);
    vcnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid_o) vcnt++;
    end
    check("midrst_no_result", vcnt + got_q.size(), 0);
    @(posedge clk);
    #1;
    run_job("post_rst", NBW'(4), pack4(2, 2, -1, 0), 3, 3, 6);

    // ---- randomized jobs against the reference model ----
    w_col[1] = -1;
    for (int i = 0; i < 24; i++) begin
      logic [NBW-1:0]   nb;
      logic [IE*MB-1:0] d;
      nb = NBW'($urandom_range(0, 15));
      d  = {$urandom};
      run_job("rand", nb, d, model(int'(nb), d, 0), model(int'(nb), d, 1), eff_n(int'(nb)) + 2);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
